mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 4-to-1 mux channel.
//   Four requesters contend for one output path. The block grants one requester at a time.
//   It drives the mux select pair {s1,s0} and a one-hot grant.
//   Each grant is held until the requester releases it or its ack-count quota expires.
//   It sits directly in front of mux4to1, with s1/s0 wired to that mux's select inputs.
// PARAMETERS
//   MAX_HOLD  8  max acked transfers per grant, legal range 1..255
//   CNT_W     8  width of the internal hold counter, must hold MAX_HOLD-1
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   req       in   4      req[i]=1: requester i wants the channel
//   ack       in   1      downstream accepted one transfer this cycle
//   s0        out  1      mux select bit 0, registered
//   s1        out  1      mux select bit 1, registered
//   gnt       out  4      one-hot grant, registered; 0000 when idle
//   busy      out  1      1 while any grant is active, equals |gnt
// BEHAVIOUR
//   Clock and reset
//     - One clock domain (clk). rst is async active-high.
//     - Reset clears immediately: gnt=0000, {s1,s0}=00, busy=0, hold_cnt=0, state=IDLE.
//     - Reset sets last=3, so the first priority order is 0,1,2,3.
//   States: IDLE, GRANT
//   Arbitration (same rule in IDLE and on GRANT release)
//     - Search order is last+1, last+2, last+3, last (mod 4).
//     - The first asserted req wins; call it w.
//     - Register gnt=1<<w and {s1,s0}=w[1:0]; hold_cnt<=0.
//     - Grant latency: req sampled at edge N gives gnt visible after edge N, i.e. 1 cycle.
//   IDLE
//     - req==0000: stay in IDLE, gnt=0000, {s1,s0} hold their last value.
//     - Otherwise arbitrate and go to GRANT.
//   GRANT (granted index g)
//     - ack=1: hold_cnt++. ack=0: hold_cnt unchanged (stall; grant held indefinitely).
//     - Release when req[g]==0 (the ack in that cycle still counts).
//     - Release also on quota expiry: ack==1 && hold_cnt==MAX_HOLD-1.
//   On release
//     - last<=g, then re-arbitrate in the same edge.
//     - Pending req: the new grant is back-to-back with no idle cycle; stay in GRANT.
//     - No pending req: gnt<=0000, go to IDLE.
//     - Quota expiry with req[g] still high: g has lowest priority.
//       g is regranted only if no other req is asserted.
//   Invariants
//     - gnt is one-hot or zero.
//     - {s1,s0} changes only on the edge that loads a new grant; stable for the whole grant.
//     - ack is ignored in IDLE.
//     - busy == |gnt.
//   Boundaries
//     - MAX_HOLD=1: release after every acked cycle, giving strict per-transfer rotation.
//     - req[g] falls and ack expires in the same cycle: a single release; hold_cnt is not double-counted.
//     - Non-granted req changes during GRANT do not affect gnt until release.
//     - rst mid-grant: outputs clear asynchronously; the first grant after reset uses order 0,1,2,3.
// TESTING
//   1 rst=1 with req=1111 -> gnt=0000, {s1,s0}=00, busy=0 throughout; release rst -> gnt=0001 one cycle later.
//   2 req=0100 single pulse for 3 cycles, ack=1 -> gnt=0100, {s1,s0}=10 for 3 cycles; gnt=0000 the cycle after req drops.
//   3 req=1111, ack=1 constant, MAX_HOLD=8 -> grants 0,1,2,3,0..., each exactly 8 cycles, no gap cycles.
//   4 grant on 2 released, then req=0101 -> gnt=0001 (order 3,0,1,2); next release -> gnt=0100.
//   5 req=0010 held, ack=0 for 20 cycles, then ack=1 -> gnt=0010 for all 20 + 8 cycles.
//     Then regranted to 1 with no gap, since it is the only requester.
//   6 async rst asserted mid-cycle during a grant on 3 -> gnt=0000 before the next edge.
//     Final: end-to-end check through mux4to1, with out equal to in[{s1,s0}] for 2000 random req/ack cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/ack inputs and select/grant outputs of the round-robin mux arbiter
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       ack;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       busy;
  modport master(output req, ack, input s0, s1, gnt, busy);
  modport slave(input req, ack, output s0, s1, gnt, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant sequencer with per-grant ack quota driving a 4-to-1 mux select
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [3:0] gnt, gnt_n;
  logic [1:0] sel, sel_n, last, last_n, base, w;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic rel;
  always_comb begin
    rel = state == GRANT && (!bus.req[sel] || (bus.ack && cnt == CNT_W'(MAX_HOLD - 1)));
    base = rel ? sel : last;
    w = base;
    // descending scan so the nearest requester after base wins
    for (int k = 4; k >= 1; k--) if (bus.req[base + 2'(k)]) w = base + 2'(k);
    last_n = base;
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    cnt_n = cnt + CNT_W'(bus.ack);
    if (state == IDLE || rel) begin
      state_n = |bus.req ? GRANT : IDLE;
      gnt_n = |bus.req ? 4'b0001 << w : 4'b0000;
      sel_n = |bus.req ? w : sel;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      last <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      sel <= sel_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  assign bus.gnt = gnt;
  assign bus.s0 = sel[0];
  assign bus.s1 = sel[1];
  assign bus.busy = |gnt;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and random checks of two arbiter instances (quota 8 and 1) against a reference model
module tb_mux4_rr_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] req = 0;
  logic ack = 0;
  logic [7:0] din[4];
  logic [7:0] out;
  int total = 0;
  int fails = 0;
  int cur[2], cnt[2], last[2], sel[2];
  int hold[2] = '{8, 1};
  mux4_rr_arbiter_if a();
  mux4_rr_arbiter_if b();
  assign a.req = req;
  assign a.ack = ack;
  assign b.req = req;
  assign b.ack = ack;
  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut0(.clk(clk), .rst(rst), .bus(a.slave));
  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1(.clk(clk), .rst(rst), .bus(b.slave));
  assign out = din[{a.s1, a.s0}];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input int l, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction
  task automatic mreset;
    for (int i = 0; i < 2; i++) begin
      cur[i] = -1;
      cnt[i] = 0;
      last[i] = 3;
      sel[i] = 0;
    end
  endtask
  task automatic mstep;
    for (int i = 0; i < 2; i++)
      if (cur[i] < 0) begin
        if (req != 0) begin
          cur[i] = pick(last[i], req);
          sel[i] = cur[i];
          cnt[i] = 0;
        end
      end else if (!req[cur[i]] || (ack && cnt[i] == hold[i] - 1)) begin
        last[i] = cur[i];
        cur[i] = pick(last[i], req);
        if (cur[i] >= 0) begin
          sel[i] = cur[i];
          cnt[i] = 0;
        end
      end else cnt[i] += int'(ack);
  endtask
  task automatic mcheck;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] g;
      logic [1:0] s;
      logic bz;
      g = i == 0 ? a.gnt : b.gnt;
      s = i == 0 ? {a.s1, a.s0} : {b.s1, b.s0};
      bz = i == 0 ? a.busy : b.busy;
      chk($sformatf("model_gnt%0d", i), g, cur[i] < 0 ? 0 : 1 << cur[i]);
      chk($sformatf("model_sel%0d", i), s, sel[i]);
      chk($sformatf("model_busy%0d", i), bz, cur[i] >= 0);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    mstep();
    #1 mcheck();
  endtask
  task automatic do_reset;
    rst = 1;
    mreset();
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    for (int k = 0; k < 4; k++) din[k] = 8'(k);
    mreset();
    req = 4'hf;
    repeat (3) begin
      @(posedge clk);
      #1 chk("t1_rst_gnt", a.gnt, 0);
      chk("t1_rst_sel", {a.s1, a.s0}, 0);
      chk("t1_rst_busy", a.busy, 0);
    end
    rst = 0;
    cyc();
    chk("t1_first_gnt", a.gnt, 4'b0001);
    do_reset();
    req = 4'b0100;
    ack = 1;
    repeat (3) begin
      cyc();
      chk("t2_gnt", a.gnt, 4'b0100);
      chk("t2_sel", {a.s1, a.s0}, 2);
    end
    req = 0;
    cyc();
    chk("t2_idle", a.gnt, 0);
    do_reset();
    req = 4'hf;
    ack = 1;
    for (int i = 0; i < 64; i++) begin
      cyc();
      chk("t3_rot8", a.gnt, 1 << ((i / 8) % 4));
      chk("t3_rot1", b.gnt, 1 << (i % 4));
    end
    do_reset();
    req = 4'b0100;
    cyc();
    chk("t4_g2", a.gnt, 4'b0100);
    req = 0;
    cyc();
    chk("t4_idle", a.gnt, 0);
    req = 4'b0101;
    cyc();
    chk("t4_g0", a.gnt, 4'b0001);
    req = 4'b0100;
    cyc();
    chk("t4_g2b", a.gnt, 4'b0100);
    do_reset();
    req = 4'b0010;
    ack = 0;
    cyc();
    repeat (20) begin
      cyc();
      chk("t5_stall", a.gnt, 4'b0010);
    end
    ack = 1;
    repeat (9) begin
      cyc();
      chk("t5_quota", a.gnt, 4'b0010);
    end
    do_reset();
    req = 4'b1000;
    cyc();
    chk("t6_g3", a.gnt, 4'b1000);
    #2 rst = 1;
    #1 chk("t6_async_gnt", a.gnt, 0);
    chk("t6_async_sel", {a.s1, a.s0}, 0);
    chk("t6_async_busy", a.busy, 0);
    mreset();
    @(posedge clk);
    #1 rst = 0;
    req = 4'hf;
    cyc();
    chk("t6_after", a.gnt, 4'b0001);
    do_reset();
    repeat (2000) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      ack = $urandom_range(3) != 0;
      for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
      cyc();
      if (cur[0] >= 0) chk("mux_out", out, din[cur[0]]);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
